// File: rtl/mac_block_param_if.sv
// Stream interface for the MAC slice: operand/config beat in, result beat out.
interface mac_block_param_if #(
  parameter int unsigned MIN_WIDTH = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_WIDTH = 48
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES*MIN_WIDTH-1:0]   a;
  logic [MIN_WIDTH-1:0]         b;
  logic [1:0]                   mode;
  logic                         signed_en;
  logic                         acc_en;
  logic                         sat_en;
  logic                         init_load;
  logic [ACC_WIDTH-1:0]         init_val;
  logic                         out_valid;
  logic                         out_ready;
  logic [ACC_WIDTH-1:0]         c;
  logic                         ovf;

  // Operand fetch side drives beats and consumes results.
  modport master (
    output in_valid, a, b, mode, signed_en, acc_en, sat_en, init_load, init_val, out_ready,
    input  in_ready, out_valid, c, ovf
  );

  // MAC slice side.
  modport slave (
    input  in_valid, a, b, mode, signed_en, acc_en, sat_en, init_load, init_val, out_ready,
    output in_ready, out_valid, c, ovf
  );
endinterface

// File: rtl/mac_block_param.sv
// Two-stage pipelined MAC slice: per-lane partial products in stage 1, composite product,
// accumulate and saturation in stage 2. Valid/ready stream with whole-pipe stall.
module mac_block_param #(
  parameter int unsigned MIN_WIDTH = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  mac_block_param_if.slave bus
);

  // Partial product width: (W+1)x(W+1) signed product, wide enough for either signedness.
  localparam int unsigned PW = 2 * MIN_WIDTH + 2;

  logic adv;
  logic accept;

  // Stage 1 registers
  logic                 s1_valid_q;
  logic [PW-1:0]        s1_pp_q [LANES];
  logic                 s1_signed_q;
  logic                 s1_acc_q;
  logic                 s1_sat_q;
  logic                 s1_init_q;
  logic [ACC_WIDTH-1:0] s1_init_val_q;

  // Stage 2 / output registers
  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] c_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;

  // Stage 1 combinational
  logic [2:0]           n_lanes;
  logic                 lanes_ok;
  logic                 top_lane;
  logic [MIN_WIDTH-1:0] lane;
  logic [PW-1:0]        lane_x;
  logic [PW-1:0]        b_x;
  logic [PW-1:0]        pp_d [LANES];

  // Stage 2 combinational
  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH-1:0] p;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   sum;
  logic                 over;
  logic [ACC_WIDTH-1:0] sat_val;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 ovf_d;

  assign adv    = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && adv;

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.ovf       = ovf_q;

  // Per-lane partial products; only the top used lane carries a sign, unused lanes are zero.
  always_comb begin
    n_lanes  = 3'd0;
    top_lane = 1'b0;
    lane     = '0;
    lane_x   = '0;
    b_x      = '0;
    unique case (bus.mode)
      2'b00:   n_lanes = 3'd1;
      2'b01:   n_lanes = 3'd2;
      2'b10:   n_lanes = 3'd4;
      default: n_lanes = 3'd0;
    endcase
    lanes_ok = (n_lanes != 3'd0) && ({29'd0, n_lanes} <= LANES);
    b_x = {{(PW - MIN_WIDTH){bus.signed_en & bus.b[MIN_WIDTH-1]}}, bus.b};
    for (int k = 0; k < int'(LANES); k++) begin
      lane     = bus.a[k*MIN_WIDTH +: MIN_WIDTH];
      top_lane = bus.signed_en && (k == int'(n_lanes) - 1);
      lane_x   = {{(PW - MIN_WIDTH){top_lane & lane[MIN_WIDTH-1]}}, lane};
      pp_d[k]  = (lanes_ok && (k < int'(n_lanes))) ? lane_x * b_x : '0;
    end
  end

  // Stage 1 register: partial products and the beat's config, loaded only on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q    <= 1'b0;
      s1_signed_q   <= 1'b0;
      s1_acc_q      <= 1'b0;
      s1_sat_q      <= 1'b0;
      s1_init_q     <= 1'b0;
      s1_init_val_q <= '0;
      for (int k = 0; k < int'(LANES); k++) s1_pp_q[k] <= '0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
      if (accept) begin
        s1_signed_q   <= bus.signed_en;
        s1_acc_q      <= bus.acc_en;
        s1_sat_q      <= bus.sat_en;
        s1_init_q     <= bus.init_load;
        s1_init_val_q <= bus.init_val;
        for (int k = 0; k < int'(LANES); k++) s1_pp_q[k] <= pp_d[k];
      end
    end
  end

  // Composite product from shifted, sign-extended partials; then accumulate with overflow handling.
  always_comb begin
    p    = '0;
    term = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      term = ACC_WIDTH'(signed'(s1_pp_q[k]));
      p    = p + (term << (k * MIN_WIDTH));
    end
    base = s1_init_q ? s1_init_val_q : acc_q;
    sum  = {1'b0, base} + {1'b0, p};
    if (s1_signed_q) begin
      over    = (base[ACC_WIDTH-1] == p[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
      sat_val = base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    end else begin
      over    = sum[ACC_WIDTH];
      sat_val = '1;
    end
    acc_d = (over && s1_sat_q) ? sat_val : sum[ACC_WIDTH-1:0];
    ovf_d = (s1_init_q ? 1'b0 : ovf_q) | over;
  end

  // Output stage: result, accumulator and sticky flag advance together with the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        if (s1_acc_q) begin
          acc_q <= acc_d;
          c_q   <= acc_d;
          ovf_q <= ovf_d;
        end else begin
          c_q <= p;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_block_param.sv
// Bench for mac_block_param: cycle-level handshake model plus an arithmetic reference that
// evaluates each beat with plain integer maths on the composite operands.
module tb_mac_block_param;
  localparam int unsigned W  = 8;
  localparam int unsigned L  = 4;
  localparam int unsigned AW = 48;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_block_param_if #(.MIN_WIDTH(W), .LANES(L), .ACC_WIDTH(AW)) bus ();

  mac_block_param #(.MIN_WIDTH(W), .LANES(L), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  logic last_acc;

  // Reference state: one slot in stage 1, one at the output, plus the architectural accumulator.
  logic          m_s1_v, m_out_v;
  logic [AW-1:0] m_s1_c, m_c, m_acc;
  logic          m_s1_ovf, m_ovf, m_acc_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1_v = 0; m_out_v = 0; m_s1_c = '0; m_c = '0; m_acc = '0;
    m_s1_ovf = 0; m_ovf = 0; m_acc_ovf = 0;
  endtask

  // Evaluate the beat currently on the bus as signed/unsigned integers.
  task automatic model_accept();
    logic signed [63:0] av, bv, pv, base, sum, maxv, minv;
    logic [63:0]        araw;
    logic [AW-1:0]      braw, res;
    logic               ov, over;
    int                 n;
    n = (bus.mode == 2'b00) ? 1 : (bus.mode == 2'b01) ? 2 : (bus.mode == 2'b10) ? 4 : 0;
    pv = 0;
    if (n != 0 && n <= int'(L)) begin
      araw = 64'(bus.a) & ((64'd1 << (n * W)) - 64'd1);
      av = araw;
      if (bus.signed_en && araw[n*W-1]) av = av - (64'sd1 << (n * W));
      bv = 64'(bus.b);
      if (bus.signed_en && bus.b[W-1]) bv = bv - (64'sd1 << W);
      pv = av * bv;
    end
    if (!bus.acc_en) begin
      res = pv[AW-1:0];
      ov  = m_acc_ovf;
    end else begin
      braw = bus.init_load ? bus.init_val : m_acc;
      base = 64'(braw);
      if (bus.signed_en && braw[AW-1]) base = base - (64'sd1 << AW);
      sum = base + pv;
      if (bus.signed_en) begin
        maxv = (64'sd1 << (AW - 1)) - 1;
        minv = -(64'sd1 << (AW - 1));
      end else begin
        maxv = (64'sd1 << AW) - 1;
        minv = 0;
      end
      over = (sum > maxv) || (sum < minv);
      if (over && bus.sat_en) res = (sum > maxv) ? maxv[AW-1:0] : minv[AW-1:0];
      else                    res = sum[AW-1:0];
      m_acc     = res;
      m_acc_ovf = (bus.init_load ? 1'b0 : m_acc_ovf) | over;
      ov        = m_acc_ovf;
    end
    m_s1_c   = res;
    m_s1_ovf = ov;
  endtask

  // One clock: check all outputs against the model at negedge, then advance the model.
  task automatic step();
    logic adv_m;
    @(negedge clk);
    adv_m = !m_out_v || bus.out_ready;
    check("in_ready", 64'(bus.in_ready), 64'(adv_m));
    check("out_valid", 64'(bus.out_valid), 64'(m_out_v));
    check("c", 64'(bus.c), 64'(m_c));
    check("ovf", 64'(bus.ovf), 64'(m_ovf));
    if (bus.out_valid && bus.out_ready) n_out++;
    last_acc = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (adv_m) begin
      if (m_s1_v) begin
        m_c   = m_s1_c;
        m_ovf = m_s1_ovf;
      end
      m_out_v  = m_s1_v;
      m_s1_v   = bus.in_valid;
      last_acc = bus.in_valid;
      if (bus.in_valid) model_accept();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] a, input logic [7:0] b, input logic [1:0] mode,
                          input logic sgn, input logic acc, input logic sat, input logic init,
                          input logic [47:0] iv);
    bus.a = a; bus.b = b; bus.mode = mode; bus.signed_en = sgn; bus.acc_en = acc;
    bus.sat_en = sat; bus.init_load = init; bus.init_val = iv;
  endtask

  // Send one beat, then expect its result exactly two advancing edges later.
  task automatic directed(input string tag, input logic [31:0] a, input logic [7:0] b,
                          input logic [1:0] mode, input logic sgn, input logic acc,
                          input logic sat, input logic init, input logic [47:0] iv,
                          input logic [47:0] exp_c);
    set_beat(a, b, mode, sgn, acc, sat, init, iv);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check(tag, 64'(bus.c), 64'(exp_c));
  endtask

  task automatic rand_beat();
    logic [47:0] iv;
    iv = {$urandom, $urandom};
    if ($urandom_range(0, 2) == 0)
      iv = ($urandom_range(0, 1) == 1) ? {32'h7FFF_FFFF, iv[15:0]} : {32'hFFFF_FFFF, iv[15:0]};
    set_beat($urandom, 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, iv);
  endtask

  initial begin
    int sent;
    logic need_new;
    model_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_beat('0, '0, 2'b00, 0, 0, 0, 0, '0);
    step();
    step();
    rst = 1'b1;
    step();

    // Single, quad and reserved mode
    directed("t1_single", 32'd200, 8'd3, 2'b00, 0, 0, 0, 0, '0, 48'd600);
    directed("t2_quad", 32'h0102_0304, 8'h10, 2'b10, 0, 0, 0, 0, '0, 48'h00_1020_3040);
    directed("t2_mode11", 32'hFFFF_FFFF, 8'hFF, 2'b11, 1, 0, 0, 0, '0, 48'd0);

    // Unsigned accumulate chain with an interleaved multiply-only beat
    directed("t3_init", 32'd5, 8'd4, 2'b00, 0, 1, 0, 1, 48'd100, 48'd120);
    directed("t3_acc", 32'd2, 8'd3, 2'b00, 0, 1, 0, 0, '0, 48'd126);
    directed("t3_mul", 32'd7, 8'd7, 2'b00, 0, 0, 0, 0, '0, 48'd49);
    directed("t3_acc2", 32'd1, 8'd1, 2'b00, 0, 1, 0, 0, '0, 48'd127);
    check("t3_ovf", 64'(bus.ovf), 64'd0);

    // Signed multiply
    directed("t4_single", 32'h0000_00FE, 8'h05, 2'b00, 1, 0, 0, 0, '0, 48'hFFFF_FFFF_FFF6);
    directed("t4_dual", 32'h0000_FFFE, 8'hFD, 2'b01, 1, 0, 0, 0, '0, 48'd6);

    // Signed saturation vs wrap, then init_load clears the sticky flag
    directed("t5_sat", 32'd10, 8'd10, 2'b00, 1, 1, 1, 1, 48'h7FFF_FFFF_FFF0, 48'h7FFF_FFFF_FFFF);
    check("t5_sat_ovf", 64'(bus.ovf), 64'd1);
    directed("t5_wrap", 32'd10, 8'd10, 2'b00, 1, 1, 0, 1, 48'h7FFF_FFFF_FFF0, 48'h8000_0000_0054);
    check("t5_wrap_ovf", 64'(bus.ovf), 64'd1);
    directed("t5_clear", 32'd1, 8'd1, 2'b00, 1, 1, 0, 1, 48'd0, 48'd1);
    check("t5_clear_ovf", 64'(bus.ovf), 64'd0);

    // Backpressure: six beats, out_ready low for three cycles
    step();
    step();
    n_out = 0;
    sent = 0;
    need_new = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.out_ready = !(cyc >= 2 && cyc < 5);
      if (sent < 6) begin
        if (need_new) rand_beat();
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (bus.in_valid && last_acc) sent++;
      need_new = last_acc;
    end
    check("t6_sent", 64'(sent), 64'd6);
    check("t6_delivered", 64'(n_out), 64'd6);

    // Reset mid-stream
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      bus.in_valid = 1'b1;
      step();
    end
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_c", 64'(bus.c), 64'd0);
    check("t6_rst_ovf", 64'(bus.ovf), 64'd0);
    check("t6_rst_ready", 64'(bus.in_ready), 64'd1);
    model_reset();
    step();
    step();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    step();

    // Random traffic with random config changes on unaccepted cycles
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
